// File: rtl/affine_interp_row_ctrl.sv
// Row sequencer for the 1/16-pel affine interpolation filter: slides a TAPS-wide
// window over the input stream and rounds, shifts and saturates the returned tree sum.
module affine_interp_row_ctrl #(
    parameter int IN_SIZE = 8,
    parameter int TAPS    = 6,
    parameter int ROW_LEN = 16,
    parameter int SUM_W   = 16,
    parameter int SHIFT   = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [3:0]              frac,
    output logic                    busy,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [IN_SIZE-1:0]      s_data,
    output logic [TAPS*IN_SIZE-1:0] win_x,
    output logic [3:0]              win_frac,
    input  logic [SUM_W-1:0]        sum_in,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [IN_SIZE-1:0]      m_data,
    output logic                    m_last
);

    localparam int IN_TOTAL = ROW_LEN + TAPS - 1;
    localparam int CNT_W    = $clog2(IN_TOTAL + 1);
    localparam int OUT_W    = $clog2(ROW_LEN + 1);

    localparam logic signed [SUM_W:0] ROUND   = (SUM_W+1)'(2 ** (SHIFT - 1));
    localparam logic signed [SUM_W:0] SAT_MAX = (SUM_W+1)'(2 ** (IN_SIZE - 1) - 1);
    localparam logic signed [SUM_W:0] SAT_MIN = (SUM_W+1)'(-(2 ** (IN_SIZE - 1)));

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN
    } state_t;

    state_t                     state_q, state_d;
    logic signed [IN_SIZE-1:0]  win_q [TAPS];
    logic [CNT_W-1:0]           in_cnt_q;
    logic [OUT_W-1:0]           out_cnt_q;
    logic [3:0]                 frac_q;
    logic                       comp_q;
    logic                       m_valid_q;
    logic [IN_SIZE-1:0]         m_data_q;
    logic                       m_last_q;

    logic                       s_acc;
    logic                       out_free;
    logic                       load_out;
    logic signed [SUM_W:0]      sum_ext;
    logic signed [SUM_W:0]      rounded;
    logic signed [SUM_W:0]      shifted;
    logic [IN_SIZE-1:0]         result;

    // comp_q marks a completed window whose output has not been registered yet
    assign out_free = !m_valid_q || m_ready;
    assign load_out = comp_q && out_free;
    assign s_acc    = s_valid && s_ready;

    // NOTE: every signal driven in an always_comb gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        s_ready = 1'b0;
        busy    = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                s_ready = 1'b1;
                if (s_valid && (in_cnt_q == CNT_W'(TAPS - 2))) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                s_ready = (in_cnt_q != CNT_W'(IN_TOTAL)) && out_free;
                if (m_valid_q && m_ready && m_last_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments only, so every flop samples
    // the pre-edge values and simulation matches the synthesised registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Rounding is done one bit wider than the sum so the offset can never wrap
    always_comb begin
        sum_ext = {sum_in[SUM_W-1], sum_in};
        rounded = sum_ext + ROUND;
        shifted = rounded >>> SHIFT;
        if (frac_q == 4'd0) begin
            result = win_q[TAPS/2-1];
        end else if (shifted > SAT_MAX) begin
            result = SAT_MAX[IN_SIZE-1:0];
        end else if (shifted < SAT_MIN) begin
            result = SAT_MIN[IN_SIZE-1:0];
        end else begin
            result = shifted[IN_SIZE-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the window is a small register array, not RAM, so it is cleared
            // element by element on reset; a true memory would be left unreset.
            for (int k = 0; k < TAPS; k++) begin
                win_q[k] <= '0;
            end
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            frac_q    <= '0;
            comp_q    <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
        end else begin
            if ((state_q == IDLE) && start) begin
                frac_q    <= frac;
                in_cnt_q  <= '0;
                out_cnt_q <= '0;
            end

            if (s_acc) begin
                for (int k = 0; k < TAPS - 1; k++) begin
                    win_q[k] <= win_q[k+1];
                end
                win_q[TAPS-1] <= s_data;
                in_cnt_q      <= in_cnt_q + CNT_W'(1);
            end

            if ((state_q == RUN) && s_acc) begin
                comp_q <= 1'b1;
            end else if (load_out) begin
                comp_q <= 1'b0;
            end

            if (load_out) begin
                m_valid_q <= 1'b1;
                m_data_q  <= result;
                m_last_q  <= (out_cnt_q == OUT_W'(ROW_LEN - 1));
                out_cnt_q <= out_cnt_q + OUT_W'(1);
            end else if (m_valid_q && m_ready) begin
                m_valid_q <= 1'b0;
                m_last_q  <= 1'b0;
            end
        end
    end

    always_comb begin
        win_x = '0;
        for (int k = 0; k < TAPS; k++) begin
            win_x[k*IN_SIZE +: IN_SIZE] = win_q[k];
        end
    end

    assign win_frac = frac_q;
    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign m_last   = m_last_q;

endmodule

// File: tb/tb_affine_interp_row_ctrl.sv
// Scoreboard bench for affine_interp_row_ctrl: models the MCM/adder tree on win_x
// and predicts every output from its own history of accepted samples.
module tb_affine_interp_row_ctrl;

    localparam int IN_SIZE  = 8;
    localparam int TAPS     = 6;
    localparam int ROW_LEN  = 4;
    localparam int SUM_W    = 16;
    localparam int SHIFT    = 6;
    localparam int IN_TOTAL = ROW_LEN + TAPS - 1;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    start;
    logic [3:0]              frac;
    logic                    busy;
    logic                    s_valid;
    logic                    s_ready;
    logic [IN_SIZE-1:0]      s_data;
    logic [TAPS*IN_SIZE-1:0] win_x;
    logic [3:0]              win_frac;
    logic [SUM_W-1:0]        sum_in;
    logic                    m_valid;
    logic                    m_ready;
    logic [IN_SIZE-1:0]      m_data;
    logic                    m_last;

    int n_cmp = 0;
    int n_err = 0;

    logic [IN_SIZE-1:0] exp_q [$];
    int                 hist  [$];
    int                 sum_mode;
    logic [SUM_W-1:0]   sum_const;

    always #5 clk = ~clk;

    // Mode 0 stands in for the MCM bank: 64*centre+31 always rounds back to centre
    always_comb begin
        sum_in = sum_const;
        if (sum_mode == 0) begin
            sum_in = SUM_W'(64 * int'($signed(win_x[(TAPS/2-1)*IN_SIZE +: IN_SIZE])) + 31);
        end
    end

    affine_interp_row_ctrl #(
        .IN_SIZE(IN_SIZE),
        .TAPS   (TAPS),
        .ROW_LEN(ROW_LEN),
        .SUM_W  (SUM_W),
        .SHIFT  (SHIFT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .frac    (frac),
        .busy    (busy),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .win_x   (win_x),
        .win_frac(win_frac),
        .sum_in  (sum_in),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last)
    );

    task automatic run_row(input string tag, input logic [3:0] f, input int mode,
                           input logic [SUM_W-1:0] sc, input logic [IN_SIZE-1:0] ec,
                           input int base, input int stall_at, input int stall_len,
                           input bit start_busy, input bit start_end);
        int n_in, n_out, stall_left, acc_cyc;
        bit held_v, seen_valid;
        logic [IN_SIZE-1:0] held_d, cur, e;
        logic held_l;
        n_in = 0; n_out = 0; stall_left = 0; acc_cyc = -1;
        held_v = 1'b0; seen_valid = 1'b0; held_d = '0; held_l = 1'b0;
        hist.delete();
        exp_q.delete();
        sum_mode  = mode;
        sum_const = sc;
        cur = (base != 0) ? IN_SIZE'(base) : IN_SIZE'($urandom_range(0, 255));

        @(negedge clk);
        start = 1'b1; frac = f; s_valid = 1'b0; m_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; frac = ~f;
        #1;
        if (busy !== 1'b1 || win_frac !== f) begin
            $display("FAIL %s start_latch: busy=%b win_frac=%0d, want busy=1 win_frac=%0d",
                     tag, busy, win_frac, f);
            n_err++;
        end
        n_cmp++;

        for (int cyc = 0; cyc < 200 && n_out < ROW_LEN; cyc++) begin
            s_valid = (n_in < IN_TOTAL);
            s_data  = cur;
            m_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            if (start_busy) begin
                start = (cyc == 3);
                frac  = 4'd3;
            end
            #1;
            if (n_in == IN_TOTAL) begin
                if (s_ready !== 1'b0) begin
                    $display("FAIL %s s_ready_after_last: got %b want 0", tag, s_ready);
                    n_err++;
                end
                n_cmp++;
            end
            if (start_busy && cyc > 3) begin
                if (win_frac !== f) begin
                    $display("FAIL %s win_frac_kept: got %0d want %0d", tag, win_frac, f);
                    n_err++;
                end
                n_cmp++;
            end
            if (m_valid && !seen_valid) begin
                seen_valid = 1'b1;
                if (cyc !== acc_cyc + 2) begin
                    $display("FAIL %s first_out_latency: at cycle %0d want %0d", tag, cyc, acc_cyc + 2);
                    n_err++;
                end
                n_cmp++;
            end
            if (m_valid && !m_ready) begin
                if (s_ready !== 1'b0) begin
                    $display("FAIL %s s_ready_stall: got %b want 0", tag, s_ready);
                    n_err++;
                end
                n_cmp++;
                if (held_v) begin
                    if ({m_data, m_last} !== {held_d, held_l}) begin
                        $display("FAIL %s hold_stable: got %h/%b want %h/%b",
                                 tag, m_data, m_last, held_d, held_l);
                        n_err++;
                    end
                    n_cmp++;
                end
                held_v = 1'b1; held_d = m_data; held_l = m_last;
            end
            if (m_valid && m_ready) begin
                held_v = 1'b0;
                if (exp_q.size() == 0) begin
                    $display("FAIL %s extra_output: got %h with empty scoreboard", tag, m_data);
                    n_err++;
                end else begin
                    e = exp_q.pop_front();
                    if (m_data !== e) begin
                        $display("FAIL %s m_data[%0d]: got %0d want %0d",
                                 tag, n_out, $signed(m_data), $signed(e));
                        n_err++;
                    end
                end
                n_cmp++;
                if (m_last !== 1'(n_out == ROW_LEN - 1)) begin
                    $display("FAIL %s m_last[%0d]: got %b want %b", tag, n_out, m_last, n_out == ROW_LEN - 1);
                    n_err++;
                end
                n_cmp++;
                n_out++;
                if (n_out == stall_at) stall_left = stall_len;
                if (start_end && n_out == ROW_LEN) begin
                    start = 1'b1;
                    frac  = 4'd5;
                end
            end
            if (s_valid && s_ready) begin
                hist.push_back(int'($signed(s_data)));
                n_in++;
                if (n_in == TAPS) acc_cyc = cyc;
                if (hist.size() >= TAPS) begin
                    exp_q.push_back(mode == 0 ? IN_SIZE'(hist[hist.size() - TAPS + TAPS/2 - 1]) : ec);
                end
                cur = (base != 0) ? IN_SIZE'(base + n_in) : IN_SIZE'($urandom_range(0, 255));
            end
            @(negedge clk);
        end

        start = 1'b0;
        frac  = f;
        s_valid = 1'b0;
        if (n_out != ROW_LEN) begin
            $display("FAIL %s row_timeout: got %0d outputs want %0d", tag, n_out, ROW_LEN);
            n_err++;
        end
        n_cmp++;
        #1;
        if ({busy, s_ready, m_valid, m_last} !== 4'b0000 || exp_q.size() != 0) begin
            $display("FAIL %s row_end_idle: busy=%b s_ready=%b m_valid=%b m_last=%b pending=%0d want all 0",
                     tag, busy, s_ready, m_valid, m_last, exp_q.size());
            n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; frac = '0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        sum_mode = 0; sum_const = '0;
        #2;
        if ({busy, s_ready, m_valid, m_last, m_data, win_frac, win_x} !== '0) begin
            $display("FAIL reset_state: got %h want 0",
                     {busy, s_ready, m_valid, m_last, m_data, win_frac, win_x});
            n_err++;
        end
        n_cmp++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_frac0_row();
        run_row("t1_frac0", 4'd0, 0, '0, '0, 1, -1, 0, 1'b0, 1'b1);
    endtask

    task automatic test_rounding();
        run_row("t2_centre", 4'd8, 0, '0, '0, 0, -1, 0, 1'b0, 1'b0);
        run_row("t2_neg33", 4'd8, 1, SUM_W'(-33), 8'hFF, 0, -1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_saturation();
        run_row("t3_sat_hi", 4'd5, 1, SUM_W'(10000), 8'h7F, 0, -1, 0, 1'b0, 1'b0);
        run_row("t3_sat_lo", 4'd5, 1, SUM_W'(-10000), 8'h80, 0, -1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_row("t4_stall", 4'd8, 0, '0, '0, 0, 1, 3, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_row();
        int n;
        n = 0;
        sum_mode = 0;
        @(negedge clk);
        start = 1'b1; frac = 4'd0;
        @(negedge clk);
        start = 1'b0; s_valid = 1'b1; m_ready = 1'b1;
        for (int cyc = 0; cyc < 50 && n < 7; cyc++) begin
            s_data = IN_SIZE'(n + 1);
            #1;
            if (s_valid && s_ready) n++;
            @(negedge clk);
        end
        s_valid = 1'b0;
        if (n != 7 || m_valid !== 1'b1 || m_data !== 8'd3) begin
            $display("FAIL t5_pre_reset: accepts=%0d m_valid=%b m_data=%0d want 7/1/3", n, m_valid, m_data);
            n_err++;
        end
        n_cmp++;
        rst_n = 1'b0;
        #1;
        if ({busy, s_ready, m_valid, m_last, m_data, win_frac, win_x} !== '0) begin
            $display("FAIL t5_reset_immediate: got %h want 0",
                     {busy, s_ready, m_valid, m_last, m_data, win_frac, win_x});
            n_err++;
        end
        n_cmp++;
        @(negedge clk);
        rst_n = 1'b1;
        run_row("t5_replay", 4'd0, 0, '0, '0, 0, -1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_start_while_busy();
        run_row("t6_start_busy", 4'd12, 0, '0, '0, 0, -1, 0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_row("b2b_a", 4'd0, 0, '0, '0, 0, -1, 0, 1'b0, 1'b0);
        run_row("b2b_b", 4'd7, 0, '0, '0, 0, 2, 1, 1'b0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_frac0_row();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_reset_mid_row();
        test_start_while_busy();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
